// File: rtl/spi_pkg.sv
// Command encoding shared by the SPI slave, spi_ram and their benches.
package spi_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_WR_ADDR = 2'b00;
  localparam cmd_t CMD_WR_DATA = 2'b01;
  localparam cmd_t CMD_RD_ADDR = 2'b10;
  localparam cmd_t CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port synchronous byte array, no reset; dout only updates on rd_en so
// a presented read byte stays put while later writes go to other addresses.
module spi_ram_array #(
  parameter int DEPTH     = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= din;
    if (rd_en) dout <= mem[addr];
  end

endmodule

// File: rtl/spi_ram.sv
// Command-decoding byte memory behind the SPI slave: one command per rx_valid pulse.
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr/rd_addr after data commands.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  logic                 rx_valid_q;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           rd_q;
  cmd_t                 cmd;
  logic                 accept;
  logic                 do_wr;
  logic                 do_rd;

  assign cmd      = cmd_t'(rx_data[9:8]);
  assign accept   = rx_valid & ~rx_valid_q;
  assign do_wr    = accept && (cmd == CMD_WR_DATA);
  assign do_rd    = accept && (cmd == CMD_RD_DATA);
  assign ram_addr = do_wr ? wr_addr : rd_addr;

  spi_ram_array #(
    .DEPTH     (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_array (
    .clk   (clk),
    .wr_en (do_wr),
    .rd_en (do_rd),
    .addr  (ram_addr),
    .din   (rx_data[7:0]),
    .dout  (rd_q)
  );

  // The array output has no reset, so gating by tx_valid gives tx_data=0
  // immediately on an asynchronous reset.
  assign tx_data = tx_valid ? rd_q : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_valid   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (accept) begin
        tx_valid <= 1'b0;
        unique case (cmd)
          CMD_WR_ADDR: wr_addr <= rx_data[ADDR_SIZE-1:0];
          CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
            wr_addr <= wr_addr + ADDR_SIZE'(1);
`endif
          end
          CMD_RD_ADDR: rd_addr <= rx_data[ADDR_SIZE-1:0];
          CMD_RD_DATA: begin
            tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_addr <= rd_addr + ADDR_SIZE'(1);
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: a monitor watches accepted commands and checks tx_* after each.
module tb_spi_ram;

  logic       clk;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one word, hold rx_valid for 'hold' cycles, then one low cycle.
  task automatic send(input logic [9:0] w, input int hold = 1);
    rx_data  = w;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] exp);
    exp_q.push_back(exp);
    send(10'h300);
  endtask

  // Monitor: tracks acceptance from the rx bus and checks outputs half a cycle later.
  logic mon_rvq = 1'b0;
  logic mon_acc;
  logic mon_rd;
  logic [7:0] mon_exp;

  initial begin
    forever begin
      @(posedge clk);
      mon_acc = !rst && rx_valid && !mon_rvq;
      mon_rd  = mon_acc && (rx_data[9:8] == 2'b11);
      mon_rvq = rst ? 1'b0 : rx_valid;
      @(negedge clk);
      if (mon_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got read data %0h with no expected entry", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("rd_tx_valid", 32'(tx_valid), 32'd1);
          chk("rd_tx_data", 32'(tx_data), 32'(mon_exp));
        end
      end else if (mon_acc) begin
        chk("non_rd_clears_tx_valid", 32'(tx_valid), 32'd0);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    #3;
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write then read of the same byte.
    send(10'h0A5);
    send(10'h13C);
    send(10'h2A5);
    rd(8'h3C);

    // Neighbours, then a long rx_valid hold on 0x11.
    send(10'h010); send(10'h15A);
    send(10'h011); send(10'h100);
    send(10'h012); send(10'h1C3);
    send(10'h011);
    send(10'h111, 12);

    send(10'h210);
`ifdef SPI_RAM_AUTOINC_EN
    rd(8'h5A); rd(8'h11); rd(8'hC3);
`else
    rd(8'h5A); rd(8'h5A); rd(8'h5A);
`endif
    send(10'h211); rd(8'h11);
    send(10'h212); rd(8'hC3);

    // Any accepted command drops tx_valid (monitor checks after 0x2B0).
    chk("tx_valid_before_drop", 32'(tx_valid), 32'd1);
    send(10'h2B0);

    // Asynchronous reset while a read is presented.
    send(10'h000); send(10'h177);
    send(10'h2A5); rd(8'h3C);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    exp_q.push_back(8'h77);  // rd_addr back at 0 after reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);

`ifdef SPI_RAM_AUTOINC_EN
    send(10'h0FF); send(10'h111); send(10'h122);
    send(10'h2FF); rd(8'h11); rd(8'h22);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_ram.md
# spi_ram

Byte-wide command-driven memory sitting directly downstream of the SPI slave. It consumes the slave's 10-bit `rx_data` words and decodes the top two bits as a command: write address, write data, read address or read data. It answers read-data commands by presenting a byte on `tx_data` with `tx_valid` for the slave to shift out on MISO.

## Interface
- `MEM_DEPTH`, default 256: number of bytes; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, default 8: address width; must be ≤ 8.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_data`  in  10  command word from the SPI slave: [9:8] command, [7:0] payload.
- `rx_valid`  in  1  slave word valid; may stay high for many cycles per word.
- `tx_data`  out  8  read byte to the slave.
- `tx_valid`  out  1  `tx_data` holds a valid read result.

## Operation
- Command encoding in `rx_data[9:8]`:
  - 00 `CMD_WR_ADDR`
  - 01 `CMD_WR_DATA`
  - 10 `CMD_RD_ADDR`
  - 11 `CMD_RD_DATA`
- Accept condition: `rx_valid`=1 and `rx_valid_q`=0, where `rx_valid_q` is `rx_valid` registered.
  - Exactly one command is executed per `rx_valid` high period, however long it lasts.
- `CMD_WR_ADDR`: `wr_addr` <= `rx_data[ADDR_SIZE-1:0]`.
- `CMD_WR_DATA`: `mem[wr_addr]` <= `rx_data[7:0]`.
- `CMD_RD_ADDR`: `rd_addr` <= `rx_data[ADDR_SIZE-1:0]`.
- `CMD_RD_DATA`: `tx_data` <= `mem[rd_addr]` and `tx_valid` <= 1. The payload bits are ignored.
- `tx_valid` control:
  - Cleared by the next accepted command of any type.
  - A new `CMD_RD_DATA` re-sets it, so it stays 1 with the new data.
  - While `tx_valid`=1, `tx_data` is stable.
- Payload bits above `ADDR_SIZE` are ignored for address commands.
- Memory contents are not reset. Address registers are independent; write and read pointers never alias.

## Timing
- Reset values (asynchronous, immediate on `rst`=1):
  - `tx_data`=0, `tx_valid`=0
  - `wr_addr`=0, `rd_addr`=0, `rx_valid_q`=0
- Reset mid-operation: a pending read is dropped and `tx_valid` falls without waiting for a clock.
- Latency:
  - A command accepted at edge N updates its registers and memory at edge N.
  - For `CMD_RD_DATA`, `tx_data`/`tx_valid` are visible after edge N and held until the next accepted command.
- Write followed by read of the same address: returns the new byte. The two commands are always on separate edges, because acceptance needs a low-to-high `rx_valid` transition.
- `rx_valid` already high when reset deasserts: treated as a new edge, because `rx_valid_q` resets to 0. One command is accepted on the first clock edge.
- `rx_valid` low for a single cycle between words: sufficient for the next word to be accepted.

## Configuration
- `SPI_RAM_AUTOINC_EN` defined:
  - After each `CMD_WR_DATA`, `wr_addr` increments.
  - After each `CMD_RD_DATA`, `rd_addr` increments, on the same edge as the memory read; the read uses the pre-increment address.
  - Increment wraps from `MEM_DEPTH-1` to 0.
- `SPI_RAM_AUTOINC_EN` not defined: addresses change only on address commands.

## Structure
- Shared package `spi_pkg`: the command localparams `CMD_WR_ADDR`, `CMD_WR_DATA`, `CMD_RD_ADDR`, `CMD_RD_DATA` and a `cmd_t` 2-bit typedef, for use by the slave bench as well.
- Sub-module `spi_ram_array`: a single-port synchronous array with write enable, address and data in, and a registered data out. It has no reset.
- The top level holds the edge detect, command decode, address registers and `tx_valid` control.

## Test plan
- Write 0x0A5 (addr 0xA5), then 0x13C (data 0x3C), then 0x2A5, then 0x3xx -> `tx_data`=0x3C, `tx_valid`=1 on the cycle after the read-data edge.
- Hold `rx_valid` high 12 cycles with 0x111 -> exactly one memory write; no change to other addresses.
- Assert `rst` asynchronously while `tx_valid`=1 -> `tx_valid`=0 and `tx_data`=0 before the next clock edge; `rd_addr`=0 afterwards.
- After a read (`tx_valid`=1), send 0x2B0 -> `tx_valid` drops one cycle after acceptance.
- With `SPI_RAM_AUTOINC_EN`:
  - Write address 0xFF, then data 0x11 and 0x22 -> `mem[0xFF]`=0x11 and `mem[0x00]`=0x22 (wrap).
  - Two read-data commands from `rd_addr` 0xFF -> 0x11, then 0x22.
- Without `SPI_RAM_AUTOINC_EN`: two read-data commands at address 0x10 holding 0x5A -> both return 0x5A; `rd_addr` stays 0x10.
